fib_rx_packet_assembler: RTL and testbench



---
 rtl/fib_rx_packet_assembler_if.sv | 36 +++
 rtl/fib_rx_packet_assembler.sv | 133 +++++++++++++
 tb/tb_fib_rx_packet_assembler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_rx_packet_assembler_if.sv
// Byte-stream input and assembled-packet output bundle
// for the FIB receive packet assembler.
interface fib_rx_packet_assembler_if;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         pkt_valid;
    logic         pkt_ready;
    logic         pkt_is_interest;
    logic [5:0]   pkt_prefix_len;
    logic [63:0]  pkt_prefix;
    logic [255:0] pkt_data;

    // Upstream byte source plus FIB sink view.
    modport master (
        output rx_valid,
        output rx_byte,
        output pkt_ready,
        input  pkt_valid,
        input  pkt_is_interest,
        input  pkt_prefix_len,
        input  pkt_prefix,
        input  pkt_data
    );

    // Assembler view.
    modport slave (
        input  rx_valid,
        input  rx_byte,
        input  pkt_ready,
        output pkt_valid,
        output pkt_is_interest,
        output pkt_prefix_len,
        output pkt_prefix,
        output pkt_data
    );
endinterface

// File: rtl/fib_rx_packet_assembler.sv
// Reassembles SPI receive bytes into one wide packet word
// and holds it in a single-entry buffer for the FIB.
module fib_rx_packet_assembler (
    input  logic                      clk,
    input  logic                      rst,
    fib_rx_packet_assembler_if.slave  bus,
    output logic                      busy,
    output logic [7:0]                drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        META,
        PREFIX,
        DATA
    } state_t;

    state_t         state;
    logic [6:0]     meta;
    logic [63:0]    cap_prefix;
    logic [255:0]   cap_data;
    logic [2:0]     prefix_cnt;
    logic [4:0]     data_cnt;

    logic           done;
    logic           can_load;
    logic [63:0]    word_prefix;
    logic [255:0]   word_data;

    // Completion detect and the finished word, including the byte on the bus.
    always_comb begin
        done        = 1'b0;
        word_prefix = cap_prefix;
        word_data   = cap_data;
        unique case (state)
            PREFIX: begin
                if (prefix_cnt == 3'd0 && meta[6]) begin
                    done        = 1'b1;
                    word_prefix = {cap_prefix[55:0], bus.rx_byte};
                    word_data   = '0;
                end
            end
            DATA: begin
                if (data_cnt == 5'd0) begin
                    done      = 1'b1;
                    word_data = {cap_data[247:0], bus.rx_byte};
                end
            end
            default: begin
            end
        endcase
    end

    // The buffer may take a new word when empty or drained this edge.
    assign can_load = !bus.pkt_valid || bus.pkt_ready;

    // Capture FSM, output buffer and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            meta                <= '0;
            cap_prefix          <= '0;
            cap_data            <= '0;
            prefix_cnt          <= '0;
            data_cnt            <= '0;
            busy                <= 1'b0;
            drop_count          <= '0;
            bus.pkt_valid       <= 1'b0;
            bus.pkt_is_interest <= 1'b0;
            bus.pkt_prefix_len  <= '0;
            bus.pkt_prefix      <= '0;
            bus.pkt_data        <= '0;
        end else begin
            if (bus.pkt_valid && bus.pkt_ready) begin
                bus.pkt_valid <= 1'b0;
            end

            if (done) begin
                if (can_load) begin
                    bus.pkt_valid       <= 1'b1;
                    bus.pkt_is_interest <= meta[6];
                    bus.pkt_prefix_len  <= meta[5:0];
                    bus.pkt_prefix      <= word_prefix;
                    bus.pkt_data        <= word_data;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        meta       <= '0;
                        cap_prefix <= '0;
                        cap_data   <= '0;
                        busy       <= 1'b1;
                        state      <= META;
                    end
                end
                META: begin
                    meta       <= bus.rx_byte[6:0];
                    prefix_cnt <= 3'd7;
                    state      <= PREFIX;
                end
                PREFIX: begin
                    cap_prefix <= {cap_prefix[55:0], bus.rx_byte};
                    prefix_cnt <= prefix_cnt - 3'd1;
                    if (prefix_cnt == 3'd0) begin
                        if (meta[6]) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            data_cnt <= 5'd31;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    cap_data <= {cap_data[247:0], bus.rx_byte};
                    data_cnt <= data_cnt - 5'd1;
                    if (data_cnt == 5'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_rx_packet_assembler.sv
// Bench for the FIB receive packet assembler: directed
// scenarios plus random traffic against a packet-level model.
module tb_fib_rx_packet_assembler;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [7:0] drop_count;

    fib_rx_packet_assembler_if bus();

    fib_rx_packet_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 0: ready high, 1: ready low, 2: random, 3: high only on completion
    int ready_mode = 0;

    // next packet as the sender will deliver it
    logic         np_int;
    logic [5:0]   np_len;
    logic [63:0]  np_pfx;
    logic [255:0] np_dat;

    // expected buffer contents and status
    logic         m_valid;
    logic         m_busy;
    int           m_drop;
    logic         m_int;
    logic [5:0]   m_len;
    logic [63:0]  m_pfx;
    logic [255:0] m_dat;

    task automatic check(input string tag,
                         input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rv(input int m);
        if (m == 0) return 1'b0;
        if (m == 1) return 1'b1;
        return 1'($urandom % 2);
    endfunction

    task automatic tick(input logic v, input logic [7:0] b,
                        input logic start, input logic done);
        logic rdy;
        bus.rx_valid = v;
        bus.rx_byte  = b;
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            2:       rdy = 1'($urandom % 2);
            default: rdy = done;
        endcase
        bus.pkt_ready = rdy;
        @(posedge clk);
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_int   = np_int;
                m_len   = np_len;
                m_pfx   = np_pfx;
                m_dat   = np_dat;
            end else if (m_drop != 255) begin
                m_drop++;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (start) m_busy = 1'b1;
        if (done) m_busy = 1'b0;
        #1;
        check("busy", 256'(busy), 256'(m_busy));
        check("pkt_valid", 256'(bus.pkt_valid), 256'(m_valid));
        check("drop_count", 256'(drop_count), 256'(m_drop));
        if (m_valid) begin
            check("is_interest", 256'(bus.pkt_is_interest), 256'(m_int));
            check("prefix_len", 256'(bus.pkt_prefix_len), 256'(m_len));
            check("prefix", 256'(bus.pkt_prefix), 256'(m_pfx));
            check("data", bus.pkt_data, m_dat);
        end
    endtask

    // abort_at > 0 stops after that many bytes following the start edge
    task automatic send_pkt(input logic [7:0] meta,
                            input logic [63:0] pfx,
                            input logic [255:0] dat,
                            input int gap,
                            input int rv_mode,
                            input int abort_at);
        logic [7:0] bytes [41];
        int n;
        int lim;
        n = meta[6] ? 9 : 41;
        lim = (abort_at > 0 && abort_at < n) ? abort_at : n;
        bytes[0] = meta;
        for (int i = 0; i < 8; i++) bytes[1+i] = pfx[63-8*i -: 8];
        for (int i = 0; i < 32; i++) bytes[9+i] = dat[255-8*i -: 8];
        np_int = meta[6];
        np_len = meta[5:0];
        np_pfx = pfx;
        np_dat = meta[6] ? '0 : dat;
        tick(1'b1, 8'($urandom), 1'b1, 1'b0);
        for (int k = 0; k < lim; k++)
            tick(rv(rv_mode), bytes[k], 1'b0, k == n - 1);
        repeat (gap) tick(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = '0;
        bus.pkt_ready = 1'b0;
        rst = 1'b1;
        #2;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_drop  = 0;
        check("rst_valid", 256'(bus.pkt_valid), 256'(0));
        check("rst_int", 256'(bus.pkt_is_interest), 256'(0));
        check("rst_len", 256'(bus.pkt_prefix_len), 256'(0));
        check("rst_prefix", 256'(bus.pkt_prefix), 256'(0));
        check("rst_data", bus.pkt_data, 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_drop", 256'(drop_count), 256'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [255:0] seq_data;
        logic [7:0]   meta;
        m_int = 1'b0;
        m_len = '0;
        m_pfx = '0;
        m_dat = '0;
        do_reset();

        // interest packet
        ready_mode = 0;
        send_pkt(8'h45, 64'h0102030405060708, rand_data(), 2, 0, 0);

        // data packet with counting payload
        for (int i = 0; i < 32; i++) seq_data[255-8*i -: 8] = 8'(i);
        send_pkt(8'h08, 64'hA0A1A2A3A4A5A6A7, seq_data, 0, 0, 0);
        check("data_first", 256'(bus.pkt_data[255:248]), 256'(8'h00));
        check("data_last", 256'(bus.pkt_data[7:0]), 256'(8'h1F));
        repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b0);

        // back-pressure: second packet dropped, first held
        ready_mode = 1;
        send_pkt(8'h43, 64'h1111111111111111, rand_data(), 0, 0, 0);
        send_pkt(8'h42, 64'h2222222222222222, rand_data(), 1, 0, 0);
        check("bp_prefix", 256'(bus.pkt_prefix), 256'(64'h1111111111111111));
        ready_mode = 0;
        repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b0);

        // same-edge handoff
        ready_mode = 3;
        send_pkt(8'h44, 64'h3333333333333333, rand_data(), 0, 0, 0);
        send_pkt(8'h46, 64'h4444444444444444, rand_data(), 0, 0, 0);
        check("handoff_prefix", 256'(bus.pkt_prefix), 256'(64'h4444444444444444));
        ready_mode = 0;
        repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b0);

        // reset mid-DATA at E20
        ready_mode = 1;
        send_pkt(8'h10, 64'h5555555555555555, rand_data(), 0, 0, 20);
        do_reset();
        repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0);
        ready_mode = 0;
        send_pkt(8'h4A, 64'h0F1E2D3C4B5A6978, rand_data(), 2, 0, 0);

        // rx_valid held high during capture is ignored
        send_pkt(8'h07, 64'hDEADBEEFCAFEF00D, rand_data(), 0, 1, 0);
        send_pkt(8'h7F, 64'h8877665544332211, rand_data(), 2, 1, 0);

        // random traffic with random back-pressure
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            meta = 8'($urandom);
            send_pkt(meta, {$urandom, $urandom}, rand_data(),
                     int'($urandom_range(0, 3)), 2, 0);
        end
        ready_mode = 0;
        repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0);

        // drop counter saturation
        do_reset();
        ready_mode = 1;
        for (int p = 0; p < 258; p++)
            send_pkt(8'h40 | 8'($urandom % 64), {$urandom, $urandom},
                     rand_data(), 0, 2, 0);
        check("drop_sat", 256'(drop_count), 256'(8'd255));
        ready_mode = 0;
        repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
